serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
// Bit-serial WIDTH-bit adder built around the existing add1bit full-adder cell.
// Operands arrive in parallel and are consumed LSB-first, one bit per clock.
// The carry is registered between bits, so the cell is the combinational core of a sequential stage.
// Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
//
// PARAMETERS
// WIDTH  8  operand/sum width in bits; legal range 1..32
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous, active-high reset
// in_valid   in   1      operand set a/b/c_in is valid
// in_ready   out  1      block can accept operands
// a          in   WIDTH  operand A
// b          in   WIDTH  operand B
// c_in       in   1      carry into bit 0
// out_valid  out  1      sum/c_out hold a completed result
// out_ready  in   1      consumer accepts the result
// sum        out  WIDTH  A+B+c_in, low WIDTH bits
// c_out      out  1      carry out of bit WIDTH-1
//
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-high (rst).
// - Reset forces state=IDLE and clears all registers (operand/sum shifters, carry, count).
//   - Outputs during and after reset: out_valid=0, sum=0, c_out=0.
//   - in_ready = (state==IDLE) & ~rst, so it is 0 while rst is high.
// - FSM states:
//   - IDLE: in_ready=1. in_valid&in_ready at an edge loads a/b into shift regs, carry<=c_in, count<=0, ->SHIFT.
//   - SHIFT: each edge, add1bit(a_sr[0], b_sr[0], carry) runs.
//     - Its sum bit shifts into sum_sr at MSB; a_sr/b_sr shift right; carry<=cell c_out; count++.
//     - At count==WIDTH-1 ->DONE.
//   - DONE: out_valid=1; sum=sum_sr and c_out=carry are stable. out_ready=1 at an edge ->IDLE.
// - Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
// - Back-to-back issue: minimum accept-to-accept spacing is WIDTH+2 cycles.
// - No overlap: in_ready=0 in SHIFT and DONE; in_valid there is ignored, a/b/c_in not sampled.
// - Backpressure: DONE holds indefinitely while out_ready=0; sum/c_out unchanged.
// - sum/c_out outside DONE:
//   - They expose the internal registers and change during SHIFT.
//   - After the DONE->IDLE handshake they hold the last result until the next load.
// - Arithmetic: {c_out,sum} == a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
// - WIDTH=1: the SHIFT state lasts one edge; count is a ceil(log2(WIDTH))-bit register, minimum 1 bit.
// - Reset mid-operation (any state) aborts the operation with no result; the next op starts clean from IDLE.
//
// STRUCTURE
// - Shared header adders_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
// - One sub-module: a single add1bit instance, the bit-slice; all sequencing lives here.
//
// TESTING (WIDTH=8 unless noted)
// 1. rst pulse, then 8'h00+8'h00 c_in=0 -> sum=8'h00 c_out=0; out_valid exactly 8 cycles after accept.
// 2. 8'hFF+8'h01 c_in=0 -> sum=8'h00 c_out=1 (full carry ripple through the register).
// 3. 8'hA5+8'h5A c_in=1 -> sum=8'h00 c_out=1; then 8'h0F+8'h01 c_in=0 -> sum=8'h10 c_out=0.
// 4. out_ready=0 for 5 cycles in DONE, in_valid pulsed -> out_valid, sum, c_out held; in_ready=0; no new op.
// 5. rst during SHIFT (3rd bit) -> out_valid=0, in_ready=1 after release; then 8'h12+8'h34 -> 8'h46 c_out=0.
// 6. 1000 random ops with random valid/ready, WIDTH=8 and WIDTH=1 -> every result equals a+b+c_in.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter-width helper.
package serial_adder_pkg;

    // Fixed encodings: Idle=0, Shift=1, Done=2.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Bit-position counter width: ceil(log2(w)), but at least one bit so WIDTH=1 still has a
    // register.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_add1bit.sv
// One-bit full-adder cell; the combinational core of each serial step.
//
// Ports:
//   a_i, b_i  operand bits
//   c_i       carry in
//   s_o       sum bit
//   c_o       carry out
module serial_adder_add1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured in parallel and added
// LSB-first, one bit per clock, through a single full-adder cell with a
// registered carry. Valid/ready handshakes on both the operand and result side.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand set a/b/c_in valid
//   in_ready   ready to accept operands (Idle and not in reset)
//   a, b       WIDTH-bit operands
//   c_in       carry into bit 0
//   out_valid  sum/c_out hold a completed result
//   out_ready  consumer accepts the result
//   sum        A+B+c_in, low WIDTH bits
//   c_out      carry out of bit WIDTH-1
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned          CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]      LastCnt = CntW'(WIDTH - 1);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]  b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
    logic              carry_q,  carry_d;
    logic [CntW-1:0]   count_q,  count_d;

    logic              cell_s;
    logic              cell_c;
    logic [WIDTH-1:0]  sum_msb;

    serial_adder_add1bit u_cell (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    // New sum bit positioned at the MSB; written this way so WIDTH=1 needs no special slice.
    always_comb begin
        sum_msb          = '0;
        sum_msb[WIDTH-1] = cell_s;
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = (sum_sr_q >> 1) | sum_msb;
                carry_d  = cell_c;
                count_d  = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
        end
    end

    // in_ready is gated by rst directly so it drops as soon as reset asserts.
    assign in_ready  = (state_q == StIdle) & ~rst;
    assign out_valid = (state_q == StDone);
    // Internal registers are exposed as-is; they only mean a result while out_valid is high.
    assign sum       = sum_sr_q;
    assign c_out     = carry_q;

endmodule
